// File: rtl/scan_pair_ctrl.sv
// scan_pair_ctrl
//   Host-side controller for two ping-ponged scanner FSMs (A and B). It tracks
//   each scanner's state from its buffer_percent, issues the command pulses that
//   keep one scanner filling while the other drains, and grants the single host
//   transfer path to one scanner at a time. A FULL scanner that waits too long
//   for the host is flushed, and each such flush is counted.
// Ports
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   enable                     allow new go_standby / start_scan commands
//   host_ready                 host can accept a transfer
//   a_percent, b_percent       scanner buffer fill, tenths (values >10 read as 10)
//   {a,b}_go_standby, _start_scan, _start_transfer, _flush   1-cycle command pulses
//   xfer_busy, xfer_sel        transfer path in use / owner (0=A, 1=B)
//   flush_count                saturating count of timeout flushes
module scan_pair_ctrl #(
  parameter int WAKE_PCT      = 8,
  parameter int FLUSH_TIMEOUT = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             host_ready,
  input  logic [3:0]       a_percent,
  input  logic [3:0]       b_percent,
  output logic             a_go_standby,
  output logic             a_start_scan,
  output logic             a_start_transfer,
  output logic             a_flush,
  output logic             b_go_standby,
  output logic             b_start_scan,
  output logic             b_start_transfer,
  output logic             b_flush,
  output logic             xfer_busy,
  output logic             xfer_sel,
  output logic [CNT_W-1:0] flush_count
);

  localparam int CW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [3:0]    WAKE4    = 4'(WAKE_PCT);
  localparam logic [CW-1:0] TMO_LAST = CW'(FLUSH_TIMEOUT - 1);

  typedef enum logic [2:0] {S_OFF, S_STBY, S_SCAN, S_FULL, S_XFER, S_FLUSH} st_t;

  st_t           st_a, st_b;
  logic          active;            // 0=A is the filling scanner, 1=B
  logic [CW-1:0] wcnt_a, wcnt_b;    // cycles spent in FULL

  logic [3:0] pa, pb, act_pct;
  st_t        act_st, peer_st;
  logic       full_a, full_b, grant_a, grant_b, tmo_a, tmo_b;
  logic       start_act, gs_act, wake_peer, hand;
  logic       ss_a, ss_b, gs_a, gs_b, drain_done;
  st_t        nst_a, nst_b;

  function automatic st_t nxt_st(st_t s, logic [3:0] p, logic gs, logic ss,
                                 logic tr, logic fl);
    nxt_st = s;
    case (s)
      S_OFF:   if (gs) nxt_st = S_STBY;
      S_STBY:  if (ss) nxt_st = S_SCAN;
      S_SCAN:  if (p == 4'd10) nxt_st = S_FULL;
      S_FULL:  if (tr) nxt_st = S_XFER; else if (fl) nxt_st = S_FLUSH;
      S_XFER,
      S_FLUSH: if (p == 4'd0) nxt_st = S_OFF;
      default: nxt_st = S_OFF;
    endcase
  endfunction

  // Counter restarts at 0 on entry to FULL, so it equals (cycles in FULL - 1).
  function automatic logic [CW-1:0] nxt_cnt(st_t s, st_t n, logic [CW-1:0] c);
    if (n != S_FULL || s != S_FULL) nxt_cnt = '0;
    else if (c != '1)               nxt_cnt = c + 1'b1;
    else                            nxt_cnt = c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] c, logic inc);
    sat_inc = (inc && c != '1) ? c + 1'b1 : c;
  endfunction

  always_comb begin
    pa      = (a_percent > 4'd10) ? 4'd10 : a_percent;
    pb      = (b_percent > 4'd10) ? 4'd10 : b_percent;
    act_st  = active ? st_b : st_a;
    peer_st = active ? st_a : st_b;
    act_pct = active ? pb : pa;

    full_a  = (st_a == S_FULL);
    full_b  = (st_b == S_FULL);
    // Longer wait count means FULL longer; equal counts cannot occur.
    grant_a = host_ready && !xfer_busy && full_a && (!full_b || wcnt_a >= wcnt_b);
    grant_b = host_ready && !xfer_busy && full_b && !grant_a;
    tmo_a   = full_a && (wcnt_a == TMO_LAST) && !grant_a;
    tmo_b   = full_b && (wcnt_b == TMO_LAST) && !grant_b;

    // Active STANDBY only happens right after startup's go_standby.
    gs_act    = enable && act_st == S_OFF && peer_st == S_OFF;
    start_act = enable && act_st == S_STBY;
    wake_peer = enable && act_st == S_SCAN && act_pct >= WAKE4 && peer_st == S_OFF;
    hand      = enable && (act_st == S_FULL || act_st == S_OFF) && peer_st == S_STBY;

    ss_a = (active ? hand : start_act) && !grant_a && !tmo_a;
    ss_b = (active ? start_act : hand) && !grant_b && !tmo_b;
    gs_a = (active ? wake_peer : gs_act) && !grant_a && !tmo_a && !ss_a;
    gs_b = (active ? gs_act : wake_peer) && !grant_b && !tmo_b && !ss_b;

    nst_a = nxt_st(st_a, pa, gs_a, ss_a, grant_a, tmo_a);
    nst_b = nxt_st(st_b, pb, gs_b, ss_b, grant_b, tmo_b);

    drain_done = xfer_busy && (xfer_sel ? (st_b == S_XFER && pb == 4'd0)
                                        : (st_a == S_XFER && pa == 4'd0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_a             <= S_OFF;
      st_b             <= S_OFF;
      active           <= 1'b0;
      wcnt_a           <= '0;
      wcnt_b           <= '0;
      a_go_standby     <= 1'b0;
      a_start_scan     <= 1'b0;
      a_start_transfer <= 1'b0;
      a_flush          <= 1'b0;
      b_go_standby     <= 1'b0;
      b_start_scan     <= 1'b0;
      b_start_transfer <= 1'b0;
      b_flush          <= 1'b0;
      xfer_busy        <= 1'b0;
      xfer_sel         <= 1'b0;
      flush_count      <= '0;
    end else begin
      st_a             <= nst_a;
      st_b             <= nst_b;
      wcnt_a           <= nxt_cnt(st_a, nst_a, wcnt_a);
      wcnt_b           <= nxt_cnt(st_b, nst_b, wcnt_b);
      if (hand) active <= ~active;
      a_go_standby     <= gs_a;
      a_start_scan     <= ss_a;
      a_start_transfer <= grant_a;
      a_flush          <= tmo_a;
      b_go_standby     <= gs_b;
      b_start_scan     <= ss_b;
      b_start_transfer <= grant_b;
      b_flush          <= tmo_b;
      if (grant_a || grant_b) begin
        xfer_busy <= 1'b1;
        xfer_sel  <= grant_b;
      end else if (drain_done) begin
        xfer_busy <= 1'b0;
      end
      flush_count <= sat_inc(sat_inc(flush_count, tmo_a), tmo_b);
    end
  end

endmodule
